// File: rtl/sync_fifo_ctrl_pkg.sv
// sync_fifo_ctrl_pkg: shared definitions for the single-clock FIFO.
//   FIFO_MODE_STD / FIFO_MODE_FWFT : read-mode selectors for the FWFT parameter
//   `FIFO_DEPTH(aw)                : capacity in words for a given address width
`ifndef FIFO_DEFS_VH
`define FIFO_DEFS_VH
`define FIFO_DEPTH(aw) (1 << (aw))
`endif

package sync_fifo_ctrl_pkg;
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;
endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// sync_fifo_ctrl_if: data/control bundle between a FIFO user and sync_fifo_ctrl.
//   master : drives i_* (flush, write, read, thresholds, error clear), samples o_*
//   slave  : the FIFO itself, samples i_* and drives o_*
interface sync_fifo_ctrl_if
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  i_flush;
  logic                  i_wr;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_rd;
  logic [ADDR_WIDTH:0]   i_afull_lim;
  logic [ADDR_WIDTH:0]   i_aempty_lim;
  logic                  i_clr_err;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic [ADDR_WIDTH:0]   o_level;
  logic                  o_full;
  logic                  o_empty;
  logic                  o_afull;
  logic                  o_aempty;
  logic                  o_overflow;
  logic                  o_underflow;

  modport master (
    output i_flush, i_wr, i_data, i_rd, i_afull_lim, i_aempty_lim, i_clr_err,
    input  o_data, o_valid, o_level, o_full, o_empty, o_afull, o_aempty,
           o_overflow, o_underflow
  );

  modport slave (
    input  i_flush, i_wr, i_data, i_rd, i_afull_lim, i_aempty_lim, i_clr_err,
    output o_data, o_valid, o_level, o_full, o_empty, o_afull, o_aempty,
           o_overflow, o_underflow
  );
endinterface

// File: rtl/fifo_sdp_ram.sv
// fifo_sdp_ram: simple dual-port storage, DATA_WIDTH x 2**ADDR_WIDTH.
//   i_we/i_waddr/i_wdata : synchronous write port
//   i_re/i_raddr         : synchronous read port, o_rdata updates only when i_re
//   i_arst_n             : resets the read register only; the array is never cleared
module fifo_sdp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n)  rdata_q <= '0;
    else if (i_re)  rdata_q <= mem_q[i_raddr];
  end

  assign o_rdata = rdata_q;
endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO controller with standard or FWFT read mode,
// programmable almost-full/almost-empty, exact fill level, sticky errors, flush.
//   i_clk, i_arst_n : clock, asynchronous active-low reset
//   bus (slave)     : flush/write/read/threshold/clear inputs, data/flag outputs
// All outputs come straight from registers.
module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = FIFO_MODE_STD
) (
  input  logic            i_clk,
  input  logic            i_arst_n,
  sync_fifo_ctrl_if.slave bus
);
  localparam int              PW      = ADDR_WIDTH + 1;
  localparam int              DEPTH   = `FIFO_DEPTH(ADDR_WIDTH);
  localparam logic [PW-1:0]   DEPTH_L = PW'(DEPTH);
  localparam bit              IS_FWFT = (FWFT == FIFO_MODE_FWFT);

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
  logic          full_q, full_d, empty_q, empty_d, afull_q, afull_d;
  logic          aempty_q, aempty_d, valid_q, valid_d, ovf_q, ovf_d, udf_q, udf_d;
  logic          wr_acc, rd_acc, ram_re;
  logic [PW-1:0] ram_cnt;

  always_comb begin
    wr_acc  = bus.i_wr & ~full_q  & ~bus.i_flush;
    rd_acc  = bus.i_rd & ~empty_q & ~bus.i_flush;
    // Words sitting in the RAM; in FWFT mode the head lives in the read register.
    ram_cnt = wptr_q - rptr_q;
    if (IS_FWFT) ram_re = ~bus.i_flush & (ram_cnt != '0) & (~valid_q | rd_acc);
    else         ram_re = rd_acc;

    wptr_d  = wptr_q + PW'(wr_acc);
    rptr_d  = rptr_q + PW'(ram_re);
    level_d = level_q;
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (IS_FWFT) valid_d = ram_re ? 1'b1 : (rd_acc ? 1'b0 : valid_q);
    else         valid_d = ram_re;

    if (bus.i_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      valid_d = 1'b0;
    end

    full_d   = (level_d == DEPTH_L);
    empty_d  = IS_FWFT ? ~valid_d : (level_d == '0);
    afull_d  = (level_d >= bus.i_afull_lim);
    aempty_d = (level_d <= bus.i_aempty_lim);

    // Clear first so a same-cycle error event wins over the clear.
    ovf_d = bus.i_clr_err ? 1'b0 : ovf_q;
    udf_d = bus.i_clr_err ? 1'b0 : udf_q;
    if (bus.i_wr & full_q  & ~bus.i_flush) ovf_d = 1'b1;
    if (bus.i_rd & empty_q & ~bus.i_flush) udf_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // The RAM read register doubles as the output stage in both modes.
  fifo_sdp_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .i_clk   (i_clk),
    .i_arst_n(i_arst_n),
    .i_we    (wr_acc),
    .i_waddr (wptr_q[ADDR_WIDTH-1:0]),
    .i_wdata (bus.i_data),
    .i_re    (ram_re),
    .i_raddr (rptr_q[ADDR_WIDTH-1:0]),
    .o_rdata (bus.o_data)
  );

  assign bus.o_valid     = valid_q;
  assign bus.o_level     = level_q;
  assign bus.o_full      = full_q;
  assign bus.o_empty     = empty_q;
  assign bus.o_afull     = afull_q;
  assign bus.o_aempty    = aempty_q;
  assign bus.o_overflow  = ovf_q;
  assign bus.o_underflow = udf_q;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed bench for a standard-mode and an FWFT-mode FIFO.
module tb_sync_fifo_ctrl;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sync_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) s_if ();
  sync_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) f_if ();

  sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) u_std (
    .i_clk(clk), .i_arst_n(arst_n), .bus(s_if));
  sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) u_fwft (
    .i_clk(clk), .i_arst_n(arst_n), .bus(f_if));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    s_if.i_flush = 0; s_if.i_wr = 0; s_if.i_rd = 0; s_if.i_data = '0; s_if.i_clr_err = 0;
    s_if.i_afull_lim = 5'd16; s_if.i_aempty_lim = 5'd0;
    f_if.i_flush = 0; f_if.i_wr = 0; f_if.i_rd = 0; f_if.i_data = '0; f_if.i_clr_err = 0;
    f_if.i_afull_lim = 5'd16; f_if.i_aempty_lim = 5'd0;
    #12;
    // reset state
    chk("rst_level", 32'(s_if.o_level), 0);
    chk("rst_empty", 32'(s_if.o_empty), 1);
    chk("rst_full", 32'(s_if.o_full), 0);
    chk("rst_afull", 32'(s_if.o_afull), 0);
    chk("rst_aempty", 32'(s_if.o_aempty), 1);
    chk("rst_valid", 32'(s_if.o_valid), 0);
    chk("rst_data", 32'(s_if.o_data), 0);
    chk("rst_ovf", 32'(s_if.o_overflow), 0);
    chk("rst_udf", 32'(s_if.o_underflow), 0);
    chk("rst_f_empty", 32'(f_if.o_empty), 1);
    @(negedge clk);
    arst_n = 1'b1;
    tick();

    // standard mode: fill, overflow, drain
    for (int i = 0; i < 16; i++) begin
      s_if.i_wr = 1; s_if.i_data = 8'(i); tick();
    end
    chk("fill_full", 32'(s_if.o_full), 1);
    chk("fill_level", 32'(s_if.o_level), 16);
    s_if.i_data = 8'hAA; tick();
    s_if.i_wr = 0;
    chk("ovf_set", 32'(s_if.o_overflow), 1);
    chk("ovf_level", 32'(s_if.o_level), 16);
    for (int i = 0; i < 16; i++) begin
      s_if.i_rd = 1; tick();
      chk("std_rd_data", 32'(s_if.o_data), 32'(i));
      chk("std_rd_valid", 32'(s_if.o_valid), 1);
    end
    s_if.i_rd = 0;
    chk("drain_empty", 32'(s_if.o_empty), 1);
    chk("drain_level", 32'(s_if.o_level), 0);
    tick();
    chk("idle_valid", 32'(s_if.o_valid), 0);
    chk("idle_hold", 32'(s_if.o_data), 32'h0F);
    s_if.i_clr_err = 1; tick(); s_if.i_clr_err = 0;
    chk("ovf_clr", 32'(s_if.o_overflow), 0);

    // thresholds
    s_if.i_afull_lim = 5'd12; s_if.i_aempty_lim = 5'd3; tick();
    chk("thr_aempty0", 32'(s_if.o_aempty), 1);
    chk("thr_afull0", 32'(s_if.o_afull), 0);
    for (int k = 1; k <= 12; k++) begin
      s_if.i_wr = 1; s_if.i_data = 8'(16 + k); tick();
      chk("thr_aempty", 32'(s_if.o_aempty), (k <= 3) ? 1 : 0);
      chk("thr_afull", 32'(s_if.o_afull), (k >= 12) ? 1 : 0);
    end
    s_if.i_wr = 0; s_if.i_afull_lim = 5'd14; tick();
    chk("thr_lim_chg", 32'(s_if.o_afull), 0);

    // flush with 9 words and a concurrent write
    for (int k = 1; k <= 3; k++) begin
      s_if.i_rd = 1; tick();
      chk("pre_flush_rd", 32'(s_if.o_data), 32'(16 + k));
    end
    s_if.i_rd = 0;
    chk("pre_flush_lvl", 32'(s_if.o_level), 9);
    s_if.i_flush = 1; s_if.i_wr = 1; s_if.i_data = 8'h99; tick();
    s_if.i_flush = 0; s_if.i_wr = 0;
    chk("flush_level", 32'(s_if.o_level), 0);
    chk("flush_empty", 32'(s_if.o_empty), 1);
    chk("flush_valid", 32'(s_if.o_valid), 0);
    chk("flush_aempty", 32'(s_if.o_aempty), 1);
    chk("flush_ovf", 32'(s_if.o_overflow), 0);
    chk("flush_udf", 32'(s_if.o_underflow), 0);
    s_if.i_wr = 1; s_if.i_data = 8'h3C; tick(); s_if.i_wr = 0;
    s_if.i_rd = 1; tick(); s_if.i_rd = 0;
    chk("post_flush_data", 32'(s_if.o_data), 32'h3C);
    chk("post_flush_lvl", 32'(s_if.o_level), 0);

    // underflow and clear priority
    s_if.i_rd = 1; tick();
    chk("udf_set", 32'(s_if.o_underflow), 1);
    chk("udf_level", 32'(s_if.o_level), 0);
    s_if.i_clr_err = 1; tick();
    chk("udf_win", 32'(s_if.o_underflow), 1);
    s_if.i_rd = 0; tick(); s_if.i_clr_err = 0;
    chk("udf_clr", 32'(s_if.o_underflow), 0);

    // FWFT: single word latency
    f_if.i_wr = 1; f_if.i_data = 8'h5A; tick(); f_if.i_wr = 0;
    chk("fw_lvl_n", 32'(f_if.o_level), 1);
    chk("fw_empty_n", 32'(f_if.o_empty), 1);
    chk("fw_valid_n", 32'(f_if.o_valid), 0);
    tick();
    chk("fw_valid_n1", 32'(f_if.o_valid), 1);
    chk("fw_data_n1", 32'(f_if.o_data), 32'h5A);
    chk("fw_empty_n1", 32'(f_if.o_empty), 0);
    f_if.i_rd = 1; tick(); f_if.i_rd = 0;
    chk("fw_pop_valid", 32'(f_if.o_valid), 0);
    chk("fw_pop_level", 32'(f_if.o_level), 0);

    // FWFT: full, then write+read together
    for (int i = 0; i < 16; i++) begin
      f_if.i_wr = 1; f_if.i_data = 8'(8'h80 + i); tick();
    end
    chk("fw_full", 32'(f_if.o_full), 1);
    chk("fw_full_lvl", 32'(f_if.o_level), 16);
    chk("fw_head", 32'(f_if.o_data), 32'h80);
    f_if.i_data = 8'h77; f_if.i_rd = 1; tick();
    f_if.i_wr = 0; f_if.i_rd = 0;
    chk("fw_rw_level", 32'(f_if.o_level), 15);
    chk("fw_rw_ovf", 32'(f_if.o_overflow), 1);
    chk("fw_rw_full", 32'(f_if.o_full), 0);
    for (int i = 1; i < 16; i++) begin
      chk("fw_drain_data", 32'(f_if.o_data), 32'(8'h80 + i));
      chk("fw_drain_valid", 32'(f_if.o_valid), 1);
      f_if.i_rd = 1; tick();
    end
    f_if.i_rd = 0;
    chk("fw_drained_valid", 32'(f_if.o_valid), 0);
    chk("fw_drained_lvl", 32'(f_if.o_level), 0);

    // asynchronous reset mid-operation
    f_if.i_wr = 1; f_if.i_data = 8'h11; tick(); tick(); f_if.i_wr = 0;
    chk("fw_pre_rst_lvl", 32'(f_if.o_level), 2);
    #2 arst_n = 1'b0; #1;
    chk("arst_level", 32'(f_if.o_level), 0);
    chk("arst_valid", 32'(f_if.o_valid), 0);
    chk("arst_ovf", 32'(f_if.o_overflow), 0);
    #5 arst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Single-clock, parametrised FIFO: the successor to the dual-clock FIFO, for buffering that stays inside one clock domain (link-layer TX/RX queues, replay buffers).
- Adds features the dual-clock FIFO lacks:
  - selectable standard or first-word-fall-through (FWFT) read mode;
  - runtime-programmable almost-full/almost-empty thresholds;
  - exact fill level output;
  - sticky overflow/underflow error flags;
  - synchronous flush.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 4, log2 of capacity; DEPTH = 2**ADDR_WIDTH words (minimum ADDR_WIDTH = 2).
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_arst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  synchronous flush, highest priority.
- i_wr  in  1  write request.
- i_data  in  DATA_WIDTH  write data.
- i_rd  in  1  read/pop request.
- i_afull_lim  in  ADDR_WIDTH+1  almost-full threshold.
- i_aempty_lim  in  ADDR_WIDTH+1  almost-empty threshold.
- i_clr_err  in  1  clears sticky error flags.
- o_data  out  DATA_WIDTH  read data.
- o_valid  out  1  o_data holds a valid word.
- o_level  out  ADDR_WIDTH+1  words stored, 0..DEPTH.
- o_full / o_empty  out  1 each  full/empty flags.
- o_afull / o_aempty  out  1 each  threshold flags.
- o_overflow / o_underflow  out  1 each  sticky error flags.

Behaviour:
- Interface fixed: one clock i_clk; reset i_arst_n is asynchronous and active-low.
- Reset values: o_level=0, o_empty=1, o_full=0, o_afull=0, o_aempty=1, o_valid=0, o_data=0, o_overflow=0, o_underflow=0, pointers=0.
- All outputs are registered and reflect the state after the current edge; there is no combinational path from inputs to outputs.
- Write accepted iff i_wr & ~o_full & ~i_flush. Read accepted iff i_rd & ~o_empty & ~i_flush. The decision uses register values at the edge.
- Capacity is exactly DEPTH words in both modes. o_level counts accepted writes minus accepted reads, including any word held in the FWFT output stage.
- Simultaneous accepted read and write: o_level unchanged, both pointers advance. A write while full is dropped even if a read occurs in the same cycle (no full bypass).
- Pointers are ADDR_WIDTH+1 bits binary and wrap modulo 2*DEPTH. Address = low ADDR_WIDTH bits.
- o_full = (level==DEPTH).
- o_afull = (level >= i_afull_lim) and o_aempty = (level <= i_aempty_lim), both computed on the next level value. A threshold change takes effect on the next edge even with no traffic.
- Standard mode (FWFT=0):
  - o_empty = (level==0).
  - A read accepted at edge N presents its word on o_data with o_valid=1 after edge N; o_valid=0 after any edge with no accepted read.
  - o_data holds its last value when no read occurs.
- FWFT mode:
  - The output stage is prefetched from RAM. o_valid=1 means o_data is the head word; o_empty = ~o_valid.
  - A write accepted at edge N into an empty FIFO gives o_valid=1 and o_data=word after edge N+1. During that cycle o_level=1 but o_empty=1.
  - A read accepted at edge N: the next word, if stored, is visible after edge N. Otherwise o_valid=0 after edge N.
- Errors: o_overflow sets on i_wr while o_full; o_underflow sets on i_rd while o_empty. Both are sticky and cleared by i_clr_err. A set in the same cycle as i_clr_err wins.
- Flush: on the next edge, pointers and level go to 0, o_valid=0, and flags return to their reset values, except afull/aempty, which are re-evaluated against level 0. Sticky error flags are unchanged. i_wr/i_rd in a flush cycle are ignored and raise no error.
- Asynchronous reset mid-operation discards all contents immediately. RAM contents are not cleared.

Decomposition:
- Shared header fifo_defs.vh, include-guarded, holds:
  - mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1;
  - a localparam-style macro for DEPTH from ADDR_WIDTH.
- One sub-module, fifo_sdp_ram:
  - simple dual-port, DATA_WIDTH x DEPTH;
  - synchronous write, synchronous registered read with read-enable;
  - no reset on the array.
- Pointer, level, flag, prefetch and error logic all live in sync_fifo_ctrl.

Test Plan:
- FWFT=0, ADDR_WIDTH=4: write 0x00..0x0F on consecutive cycles, then one more write of 0xAA -> o_full=1 and o_level=16 after the 16th write; 0xAA dropped, o_overflow=1. Then 16 reads -> data 0x00..0x0F in order, one cycle after each read.
- FWFT=1: single write 0x5A into empty FIFO at edge N -> o_level=1 after N; o_valid=1, o_data=0x5A, o_empty=0 after N+1. i_rd -> o_valid=0, o_level=0 after the next edge.
- FIFO full (16 words), i_wr=1 with 0x77 and i_rd=1 together -> head popped, write rejected, o_level=15, o_overflow=1, o_full=0.
- i_afull_lim=12, i_aempty_lim=3, write 12 words -> o_aempty falls after the 4th write, o_afull rises after the 12th. Change i_afull_lim to 14 -> o_afull=0 next edge.
- Mid-stream with 9 words, assert i_flush with i_wr=1 -> o_level=0, o_empty=1, o_valid=0, no error. Subsequent write of 0x3C reads back as 0x3C.
- Empty FIFO, i_rd=1 -> o_underflow=1, o_level stays 0. i_clr_err and i_rd same cycle -> o_underflow stays 1. i_clr_err alone -> 0.
